// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: ALU ops, iterative shift-add MUL, branch/jump targets, registered output slot.
// Optional build macro SAT_ARITH_EN: ADD/SUB (and the JR sum) saturate on signed overflow.
module ex_stage_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] reg2,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  input  logic [SHW-1:0]   shamt,
  input  logic [2:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic [WIDTH-1:0] target
);

  localparam logic [3:0] OP_SUB = 4'd1, OP_AND = 4'd2, OP_NOR = 4'd3, OP_SLL = 4'd4,
                         OP_SRL = 4'd5, OP_SRA = 4'd6, OP_MUL = 4'd7, OP_BR  = 4'd8,
                         OP_JR  = 4'd9;
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   CNT_INIT = SHW'(WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_nextState;
  logic             r_outValid;
  logic [WIDTH-1:0] r_result, r_target, r_mcand, r_prodHi, r_prodLo, r_mulTarget;
  logic [2:0]       r_flags;
  logic [SHW-1:0]   r_cnt;

  logic [WIDTH-1:0] w_src1, w_sum, w_diff, w_addRes, w_subRes, w_aluRes, w_pcTarget, w_aluTarget;
  logic             w_addOv, w_subOv, w_aluV, w_keepFlags;
  logic [2:0]       w_aluFlags;
  logic [WIDTH:0]   w_mulSum;
  logic             w_slotFree, w_accept, w_loadAlu, w_loadMul, w_startMul;

  assign w_src1     = alu_src ? reg2 : imm;
  assign w_sum      = src0 + w_src1;
  assign w_diff     = src0 - w_src1;
  assign w_addOv    = (src0[WIDTH-1] == w_src1[WIDTH-1]) && (w_sum[WIDTH-1] != src0[WIDTH-1]);
  assign w_subOv    = (src0[WIDTH-1] != w_src1[WIDTH-1]) && (w_diff[WIDTH-1] != src0[WIDTH-1]);
  assign w_pcTarget = pc + imm + WIDTH'(1);

`ifdef SAT_ARITH_EN
  // Overflow direction follows the sign of src0: a positive src0 can only overflow upward.
  assign w_addRes = w_addOv ? (src0[WIDTH-1] ? MIN_NEG : MAX_POS) : w_sum;
  assign w_subRes = w_subOv ? (src0[WIDTH-1] ? MIN_NEG : MAX_POS) : w_diff;
`else
  assign w_addRes = w_sum;
  assign w_subRes = w_diff;
`endif

  always_comb begin
    w_aluRes    = w_addRes;
    w_aluV      = w_addOv;
    w_keepFlags = 1'b0;
    case (op)
      OP_SUB: begin w_aluRes = w_subRes;              w_aluV = w_subOv;     end
      OP_AND: begin w_aluRes = src0 & w_src1;         w_aluV = flags_in[0]; end
      OP_NOR: begin w_aluRes = ~(src0 | w_src1);      w_aluV = flags_in[0]; end
      OP_SLL: begin w_aluRes = src0 << shamt;         w_aluV = flags_in[0]; end
      OP_SRL: begin w_aluRes = src0 >> shamt;         w_aluV = flags_in[0]; end
      OP_SRA: begin w_aluRes = $signed(src0) >>> shamt; w_aluV = flags_in[0]; end
      OP_BR:  begin w_aluRes = w_sum;                 w_keepFlags = 1'b1;   end
      OP_JR:  begin w_aluRes = w_addRes;              w_keepFlags = 1'b1;   end
      default: ;
    endcase
  end

  assign w_aluFlags  = w_keepFlags ? flags_in : {w_aluRes[WIDTH-1], ~|w_aluRes, w_aluV};
  assign w_aluTarget = (op == OP_JR) ? w_aluRes : w_pcTarget;

  assign w_mulSum   = {1'b0, r_prodHi} + (r_prodLo[0] ? {1'b0, r_mcand} : '0);
  assign w_slotFree = !r_outValid || out_ready;
  assign in_ready   = (r_state == S_IDLE) && w_slotFree;
  assign w_accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_loadAlu   = 1'b0;
    w_loadMul   = 1'b0;
    w_startMul  = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (op == OP_MUL) begin
          w_startMul  = 1'b1;
          w_nextState = S_RUN;
        end else begin
          w_loadAlu = 1'b1;
        end
      end
      S_RUN:  if (r_cnt == '0) w_nextState = S_DONE;
      S_DONE: if (w_slotFree) begin
        w_loadMul   = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Product register {hi,lo} starts with the multiplier in lo and shifts right one bit per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand     <= '0;
      r_prodHi    <= '0;
      r_prodLo    <= '0;
      r_cnt       <= '0;
      r_mulTarget <= '0;
    end else if (w_startMul) begin
      r_mcand     <= src0;
      r_prodHi    <= '0;
      r_prodLo    <= w_src1;
      r_cnt       <= CNT_INIT;
      r_mulTarget <= w_pcTarget;
    end else if (r_state == S_RUN) begin
      r_prodHi <= w_mulSum[WIDTH:1];
      r_prodLo <= {w_mulSum[0], r_prodLo[WIDTH-1:1]};
      r_cnt    <= r_cnt - SHW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
      r_target   <= '0;
    end else if (w_loadAlu) begin
      r_outValid <= 1'b1;
      r_result   <= w_aluRes;
      r_flags    <= w_aluFlags;
      r_target   <= w_aluTarget;
    end else if (w_loadMul) begin
      r_outValid <= 1'b1;
      r_result   <= r_prodLo;
      r_flags    <= {r_prodLo[WIDTH-1], ~|r_prodLo, |r_prodHi};
      r_target   <= r_mulTarget;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign target    = r_target;

endmodule
